// File: rtl/regfile_2r1w_clr.sv
// Register file: 2 combinational read ports, 1 write port, synchronous reset and a one-entry-per-cycle clear engine.
// Optional macro REGFILE_2R1W_CLR_BYPASS_EN adds same-cycle write-to-read forwarding in IDLE.
module regfile_2r1w_clr #(
  parameter int unsigned p_nwords = 8,
  parameter int unsigned p_nbits  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wen,
  input  logic [$clog2(p_nwords)-1:0] waddr,
  input  logic [p_nbits-1:0]          wdata,
  input  logic [$clog2(p_nwords)-1:0] raddr0,
  output logic [p_nbits-1:0]          rdata0,
  input  logic [$clog2(p_nwords)-1:0] raddr1,
  output logic [p_nbits-1:0]          rdata1,
  input  logic                        clear,
  output logic                        busy
);

  localparam int unsigned AW = $clog2(p_nwords);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      cnt_q, cnt_d;
  logic [p_nbits-1:0] mem_q [p_nwords];
  logic [p_nbits-1:0] mem_d [p_nwords];

  // Next-state: writes only in IDLE; CLEAR zeroes entry cnt_q and steps the counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    case (state_q)
      ST_IDLE: begin
        // Ternary rather than if so an unknown wen/clear propagates X.
        mem_d[waddr] = wen ? wdata : mem_q[waddr];
        state_d      = clear ? ST_CLEAR : ST_IDLE;
        cnt_d        = '0;
      end
      ST_CLEAR: begin
        mem_d[cnt_q] = '0;
        cnt_d        = cnt_q + AW'(1);
        if (cnt_q == AW'(p_nwords - 1)) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
    end
  end

  assign busy = (state_q == ST_CLEAR);

`ifdef REGFILE_2R1W_CLR_BYPASS_EN
  // Forward only writes that will actually commit, i.e. not those dropped during CLEAR.
  assign rdata0 = (wen && (state_q == ST_IDLE) && (waddr == raddr0)) ? wdata : mem_q[raddr0];
  assign rdata1 = (wen && (state_q == ST_IDLE) && (waddr == raddr1)) ? wdata : mem_q[raddr1];
`else
  assign rdata0 = mem_q[raddr0];
  assign rdata1 = mem_q[raddr1];
`endif

endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// Directed plus random bench for regfile_2r1w_clr against an array-based reference model.
module tb_regfile_2r1w_clr;

  localparam int NW = 8;
  localparam int AW = 3;
  localparam int NB = 8;

`ifdef REGFILE_2R1W_CLR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [NB-1:0] wdata;
  logic [AW-1:0] raddr0;
  logic [NB-1:0] rdata0;
  logic [AW-1:0] raddr1;
  logic [NB-1:0] rdata1;
  logic          clear;
  logic          busy;

  regfile_2r1w_clr #(.p_nwords(NW), .p_nbits(NB)) dut (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr0(raddr0), .rdata0(rdata0), .raddr1(raddr1), .rdata1(rdata1),
    .clear(clear), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: contents plus number of clear edges still owed.
  logic [NB-1:0] m_mem [NW];
  int            m_left;

  task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply the behavioural rules for one clock edge using the inputs currently driven.
  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < NW; i++) m_mem[i] = '0;
      m_left = 0;
    end else if (m_left > 0) begin
      m_mem[NW - m_left] = '0;
      m_left--;
    end else begin
      if (wen) m_mem[waddr] = wdata;
      if (clear) m_left = NW;
    end
  endtask

  function automatic logic [NB-1:0] exp_rd(input logic [AW-1:0] a);
    if (BYP && wen && (m_left == 0) && (waddr == a)) return wdata;
    return m_mem[a];
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [NB-1:0] d);
    wen = 1'b1; waddr = a; wdata = d;
    tick();
    wen = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [NB-1:0] exp_const, input bit use_const);
    for (int i = 0; i < NW; i++) begin
      raddr0 = AW'(i);
      raddr1 = AW'(NW - 1 - i);
      #1;
      chk({tag, "_p0"}, rdata0, use_const ? exp_const : exp_rd(raddr0));
      chk({tag, "_p1"}, rdata1, use_const ? exp_const : exp_rd(raddr1));
    end
  endtask

  int bc;

  initial begin
    rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0;
    raddr0 = '0; raddr1 = '0; clear = 1'b0;
    for (int i = 0; i < NW; i++) m_mem[i] = 'x;
    m_left = 0;
    @(negedge clk);
    tick();
    rst = 1'b0;

    // 1: preload 0xAA, reset, everything reads zero
    for (int i = 0; i < NW; i++) write(AW'(i), 8'hAA);
    check_all("preload", 8'hAA, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all("reset", 8'h00, 1'b1);
    chk("reset_busy", 8'(busy), 8'h00);

    // 2: basic write/read and same-address reads
    write(3'd5, 8'h3C);
    write(3'd2, 8'h81);
    raddr0 = 3'd5; raddr1 = 3'd2; #1;
    chk("wr5", rdata0, 8'h3C);
    chk("wr2", rdata1, 8'h81);
    raddr0 = 3'd5; raddr1 = 3'd5; #1;
    chk("same_addr", rdata1, 8'h3C);
    chk("same_addr_eq", rdata0, rdata1);

    // 3: clear timing
    for (int i = 0; i < NW; i++) write(AW'(i), NB'(i + 1));
    clear = 1'b1; #1;
    chk("busy_not_comb", 8'(busy), 8'h00);
    tick();
    clear = 1'b0;
    bc = 0;
    for (int g = 0; g < 20 && busy; g++) begin
      bc++;
      if (bc == 4) begin
        raddr0 = 3'd2; raddr1 = 3'd3; #1;
        chk("clr3_e2", rdata0, 8'h00);
        chk("clr3_e3", rdata1, 8'h04);
        raddr0 = 3'd0; #1;
        chk("clr3_e0", rdata0, 8'h00);
      end
      tick();
    end
    chk("busy_len", 8'(bc), 8'(NW));
    check_all("after_clear", 8'h00, 1'b1);

    // 4: collisions
    wen = 1'b1; waddr = 3'd7; wdata = 8'h55; clear = 1'b1;
    tick();
    wen = 1'b0; clear = 1'b0;
    bc = 0;
    for (int g = 0; g < 20 && busy; g++) begin
      bc++;
      wen = (bc == 5); waddr = 3'd1; wdata = 8'hEE;
      clear = (bc == 3);
      raddr0 = 3'd7; raddr1 = 3'd1; #1;
      chk("coll_e7", rdata0, 8'h55);
      chk("coll_e1", rdata1, exp_rd(3'd1));
      tick();
    end
    wen = 1'b0; clear = 1'b0;
    chk("coll_busy_len", 8'(bc), 8'(NW));
    raddr0 = 3'd7; raddr1 = 3'd1; #1;
    chk("coll_e7_zero", rdata0, 8'h00);
    chk("coll_e1_dropped", rdata1, 8'h00);

    // 5: reset mid-clear
    for (int i = 0; i < NW; i++) write(AW'(i), NB'(8'hC0 + i));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("midclr_busy", 8'(busy), 8'h01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midclr_busy_off", 8'(busy), 8'h00);
    check_all("midclr_zero", 8'h00, 1'b1);
    write(3'd4, 8'h77);
    raddr0 = 3'd4; #1;
    chk("midclr_write", rdata0, 8'h77);

    // 6: same-cycle read of a write
    write(3'd3, 8'h11);
    wen = 1'b1; waddr = 3'd3; wdata = 8'h9E; raddr0 = 3'd3; #1;
    chk("bypass_same", rdata0, BYP ? 8'h9E : 8'h11);
    tick();
    wen = 1'b0; #1;
    chk("bypass_next", rdata0, 8'h9E);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst    = ($urandom_range(0, 99) == 0);
      clear  = ($urandom_range(0, 29) == 0);
      wen    = 1'($urandom_range(0, 1));
      waddr  = AW'($urandom_range(0, NW - 1));
      wdata  = NB'($urandom);
      raddr0 = AW'($urandom_range(0, NW - 1));
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, NW - 1));
      #1;
      chk("rnd_rd0", rdata0, exp_rd(raddr0));
      chk("rnd_rd1", rdata1, exp_rd(raddr1));
      chk("rnd_busy", 8'(busy), 8'(m_left > 0));
      tick();
    end
    rst = 1'b0; wen = 1'b0; clear = 1'b0;
    check_all("final", 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w_clr.md
Name: regfile_2r1w_clr

Overview:
Parametrised register file with 2 combinational read ports and 1 sequential write port.
- Synchronous reset clears the whole array in one cycle.
- A sequential clear engine zeroes one entry per cycle on request and reports busy while it runs.
- Generalises the flat 4x4b 1r1w regfile; used as the architectural register file and as a scratch buffer in datapath labs.

Parameters:
p_nwords, 8, number of entries; power of two, >= 2
p_nbits, 8, bits per entry; >= 1

Ports:
clk     input   1                     clock; all state updates on posedge
rst     input   1                     synchronous, active-high reset
wen     input   1                     write enable
waddr   input   $clog2(p_nwords)      write address
wdata   input   p_nbits               write data
raddr0  input   $clog2(p_nwords)      read address, port 0
rdata0  output  p_nbits               read data, port 0 (combinational)
raddr1  input   $clog2(p_nwords)      read address, port 1
rdata1  output  p_nbits               read data, port 1 (combinational)
clear   input   1                     request to zero all entries via clear engine
busy    output  1                     high while clear engine is running

Behaviour:
- Reset: with rst high at a posedge, every entry becomes 0, FSM goes to IDLE, clear counter becomes 0, busy=0.
  - rst has priority over wen, clear and an in-progress clear (reset mid-clear aborts it; array is fully zero anyway).
- Reads: rdataN = array[raddrN] combinationally, zero latency. Both ports are independent; the same address on both ports is legal.
- Writes (IDLE only): if wen=1 at a posedge, array[waddr] <= wdata. Visible on reads the cycle after the edge, unless the bypass feature is enabled.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR at a posedge with clear=1 and rst=0; counter <= 0.
  - In CLEAR, each posedge: array[counter] <= 0, counter <= counter+1.
  - When counter == p_nwords-1, that entry is zeroed and the FSM returns to IDLE; counter wraps to 0.
- busy = (state == CLEAR), driven from state only, not combinational from clear. busy is high for exactly p_nwords cycles, starting the cycle after clear is sampled.
- Simultaneous events:
  - wen and clear in the same IDLE cycle: the write commits at that edge; the clear engine zeroes it later.
  - wen during CLEAR: the write is dropped silently. Callers must check busy.
  - clear during CLEAR: ignored; no restart, no extension.
  - clear held high continuously: after returning to IDLE, the FSM re-enters CLEAR at the next edge.
- Reads during CLEAR return current contents: already-cleared entries read 0, others read their old value.
- X-propagation:
  - wen unknown while in IDLE: array[waddr] becomes X.
  - clear unknown while in IDLE: state becomes X.
- Unused/undriven signals are flagged with the standard lint macros.

Optional Feature:
REGFILE_2R1W_CLR_BYPASS_EN
- Defined: write-to-read forwarding on both ports. If wen=1, state=IDLE and waddrN... more precisely, if waddr == raddrN, then rdataN = wdata in the same cycle. This forms a combinational path from wdata/waddr/wen to rdata. No forwarding during CLEAR, because dropped writes are not forwarded.
- Undefined: reads always return stored array contents; the new value appears the cycle after the write edge.

Test Plan:
1. Reset (p_nwords=8, p_nbits=8): pre-load all entries 0xAA, pulse rst 1 cycle -> both ports read 0x00 at every address; busy=0.
2. Basic write/read: write 0x3C to addr 5, then 0x81 to addr 2; read raddr0=5, raddr1=2 -> 0x3C / 0x81. Same-address read on both ports -> equal data.
3. Clear timing: fill entries with i+1, assert clear 1 cycle -> busy high for exactly 8 cycles. After the 3rd CLEAR edge, entries 0-2 read 0 and entry 3 reads 0x04. After busy falls, all read 0.
4. Collisions: wen+clear same cycle writing 0x55 to addr 7 -> 7 reads 0x55 until zeroed on the 8th CLEAR edge. wen to addr 1 during CLEAR -> addr 1 stays 0 afterward. clear re-pulsed mid-CLEAR -> busy still 8 cycles total.
5. Reset mid-clear: start clear, assert rst on the 4th CLEAR cycle -> next cycle busy=0, state IDLE, all entries 0; new write succeeds immediately.
6. Bypass (macro defined): wen=1, waddr=3, wdata=0x9E, raddr0=3 -> rdata0=0x9E in the same cycle. Macro undefined -> old value in the same cycle, 0x9E next cycle.
